nib_word_buffer: RTL

NIB_WORD_BUFFER -- requirements
Module: nib_word_buffer

---
 rtl/nib_word_buffer_pkg.sv | 23 ++
 rtl/nib_word_buffer_if.sv | 23 ++
 rtl/nib_word_rdfsm.sv | 71 +++++++
 rtl/nib_word_buffer.sv | 98 +++++++++
 4 files changed

// File: rtl/nib_word_buffer_pkg.sv
// Shared constants and types for the nibble-to-word buffer.
// Buffer geometry and the read-FSM state encoding live here.
package nib_word_buffer_pkg;

  localparam int unsigned DEPTH_WORDS   = 1024;
  localparam int unsigned NIBS_PER_WORD = 4;
  localparam int unsigned WORD_AW       = 10;
  localparam int unsigned NIB_AW        = 12;
  localparam int unsigned WORD_W        = 16;

  // One extra bit on every count so "full" and "empty" differ.
  typedef logic [NIB_AW:0]  nib_cnt_t;
  typedef logic [WORD_AW:0] word_cnt_t;

  localparam nib_cnt_t FULL_FILL = nib_cnt_t'(DEPTH_WORDS * NIBS_PER_WORD);

  typedef enum logic [1:0] {
    RD_EMPTY = 2'd0,
    RD_FETCH = 2'd1,
    RD_VALID = 2'd2
  } rd_state_e;

endpackage

// File: rtl/nib_word_buffer_if.sv
// Nibble input stream and word output stream of the buffer.
// slave = buffer side, master = producer/consumer side.
interface nib_word_buffer_if;
  import nib_word_buffer_pkg::*;

  logic              s_valid_i;
  logic              s_ready_o;
  logic [3:0]        s_data_i;
  logic              m_valid_o;
  logic              m_ready_i;
  logic [WORD_W-1:0] m_data_o;

  modport slave (
    input  s_valid_i, s_data_i, m_ready_i,
    output s_ready_o, m_valid_o, m_data_o
  );

  modport master (
    output s_valid_i, s_data_i, m_ready_i,
    input  s_ready_o, m_valid_o, m_data_o
  );

endinterface

// File: rtl/nib_word_rdfsm.sv
// Read FSM: issues one RAM word read, registers the result, holds it until taken.
// Two cycles per word; m_valid_o/m_data_o stay stable while m_ready_i is low.
module nib_word_rdfsm
  import nib_word_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              avail_i,
  output logic              rd_issue_o,
  output logic              hs_o,
  input  logic [WORD_W-1:0] ram_doa_i,
  input  logic              m_ready_i,
  output logic              m_valid_o,
  output logic [WORD_W-1:0] m_data_o
);

  rd_state_e         state_q, state_d;
  logic [WORD_W-1:0] data_q, data_d;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    rd_issue_o = 1'b0;
    hs_o       = 1'b0;
    unique case (state_q)
      RD_EMPTY: begin
        if (avail_i) begin
          rd_issue_o = 1'b1;
          state_d    = RD_FETCH;
        end
      end
      RD_FETCH: begin
        data_d  = ram_doa_i;
        state_d = RD_VALID;
      end
      RD_VALID: begin
        if (m_ready_i) begin
          hs_o = 1'b1;
          // Back-to-back: next read goes out in the handshake cycle.
          if (avail_i) begin
            rd_issue_o = 1'b1;
            state_d    = RD_FETCH;
          end else begin
            state_d = RD_EMPTY;
          end
        end
      end
      default: state_d = RD_EMPTY;
    endcase
    if (flush_i) begin
      state_d    = RD_EMPTY;
      rd_issue_o = 1'b0;
      hs_o       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RD_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign m_valid_o = (state_q == RD_VALID);
  assign m_data_o  = data_q;

endmodule

// File: rtl/nib_word_buffer.sv
// 1024-word FIFO packing 4-bit nibbles into 16-bit words via an external dual-width RAM.
// Word readable 3 cycles after its last nibble; s_ready_o drops at 4096 buffered nibbles.
module nib_word_buffer
  import nib_word_buffer_pkg::*;
#(
  parameter int unsigned DELAY = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  nib_word_buffer_if.slave bus,
  output logic [10:0]  level_o,
  output logic         ram_enb_o,
  output logic         ram_web_o,
  output logic [11:0]  ram_addrb_o,
  output logic [3:0]   ram_dib_o,
  output logic         ram_ena_o,
  output logic [1:0]   ram_wea_o,
  output logic [9:0]   ram_addra_o,
  input  logic [15:0]  ram_doa_i
);

  // Registered outputs update without delay; DELAY is kept for drop-in compatibility.
  localparam logic [31:0] DELAY_NS = 32'(DELAY);
  logic unused_delay;
  assign unused_delay = ^DELAY_NS;

  nib_cnt_t  wp_q, wp_d;
  word_cnt_t cw_q, cw_d;   // committed words
  word_cnt_t rp_q, rp_d;   // reads issued
  word_cnt_t cp_q, cp_d;   // words handshaken
  nib_cnt_t  fill;
  logic      nib_acc, rd_issue, hs, avail;

  assign fill          = wp_q - nib_cnt_t'({cp_q, 2'b00});
  assign bus.s_ready_o = (fill != FULL_FILL);
  assign nib_acc       = bus.s_valid_i & bus.s_ready_o & ~flush_i;
  assign avail         = (cw_q != rp_q);

  always_comb begin
    wp_d = wp_q;
    cw_d = cw_q;
    rp_d = rp_q;
    cp_d = cp_q;
    if (flush_i) begin
      wp_d = '0;
      cw_d = '0;
      rp_d = '0;
      cp_d = '0;
    end else begin
      if (nib_acc) begin
        wp_d = wp_q + nib_cnt_t'(1);
        // Commit only whole words, so the reader never sees a partial one.
        if (wp_q[1:0] == 2'(NIBS_PER_WORD - 1))
          cw_d = cw_q + word_cnt_t'(1);
      end
      if (rd_issue) rp_d = rp_q + word_cnt_t'(1);
      if (hs)       cp_d = cp_q + word_cnt_t'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp_q <= '0;
      cw_q <= '0;
      rp_q <= '0;
      cp_q <= '0;
    end else begin
      wp_q <= wp_d;
      cw_q <= cw_d;
      rp_q <= rp_d;
      cp_q <= cp_d;
    end
  end

  assign ram_enb_o   = nib_acc;
  assign ram_web_o   = nib_acc;
  assign ram_addrb_o = wp_q[NIB_AW-1:0];
  assign ram_dib_o   = bus.s_data_i;
  assign ram_ena_o   = rd_issue;
  assign ram_wea_o   = 2'b00;
  assign ram_addra_o = rp_q[WORD_AW-1:0];
  assign level_o     = cw_q - cp_q;

  nib_word_rdfsm u_rdfsm (
    .clk        (clk_i),
    .rst        (rst_i),
    .flush_i    (flush_i),
    .avail_i    (avail),
    .rd_issue_o (rd_issue),
    .hs_o       (hs),
    .ram_doa_i  (ram_doa_i),
    .m_ready_i  (bus.m_ready_i),
    .m_valid_o  (bus.m_valid_o),
    .m_data_o   (bus.m_data_o)
  );

endmodule
